// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: control sequencer for a shared-datapath multicycle MIPS
// (one ALU, one unified memory port, one register file). Decodes R-type, lw, sw,
// beq, bne, j, addi and andi. Supports memory wait states, a per-access timeout
// and a sticky FAULT state.
// Optional build macro MULTICYCLE_PERF_CNT_EN adds the CycleCount/InstrCount outputs.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OpCode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       Fault
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0] CycleCount,
  output logic [31:0] InstrCount
`endif
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    I_EXEC   = 4'd11,
    I_WB     = 4'd12,
    FAULT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  // The counter only has to reach MEM_TIMEOUT-1; with the timeout disabled it just wraps.
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t           state;
  state_t           next_state;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             mem_timeout;

  // Timeout fires only on a non-ready cycle, so MemReady in the final cycle wins.
  always_comb begin
    in_wait     = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    mem_timeout = (MEM_TIMEOUT != 0) && in_wait && !MemReady &&
                  (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  end

  // Next-state selection.
  always_comb begin
    next_state = FAULT;
    case (state)
      IDLE:     next_state = FETCH;
      FETCH:    next_state = MemReady ? DECODE : (mem_timeout ? FAULT : FETCH);
      DECODE: begin
        case (OpCode)
          OP_LW, OP_SW:     next_state = MEM_ADDR;
          OP_RTYPE:         next_state = R_EXEC;
          OP_BEQ, OP_BNE:   next_state = BRANCH;
          OP_J:             next_state = JUMP;
          OP_ADDI, OP_ANDI: next_state = I_EXEC;
          default:          next_state = FAULT;
        endcase
      end
      MEM_ADDR: begin
        if (op_q == OP_LW)      next_state = MEM_RD;
        else if (op_q == OP_SW) next_state = MEM_WR;
        else                    next_state = FAULT;
      end
      MEM_RD:   next_state = MemReady ? MEM_WB : (mem_timeout ? FAULT : MEM_RD);
      MEM_WB:   next_state = FETCH;
      MEM_WR:   next_state = MemReady ? FETCH : (mem_timeout ? FAULT : MEM_WR);
      R_EXEC:   next_state = R_WB;
      R_WB:     next_state = FETCH;
      BRANCH:   next_state = FETCH;
      JUMP:     next_state = FETCH;
      I_EXEC:   next_state = I_WB;
      I_WB:     next_state = FETCH;
      default:  next_state = FAULT;
    endcase
  end

  // State, latched opcode and memory wait counter.
  // Any state change clears the counter, which covers every entry into a wait state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        op_q <= OpCode;
      end
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (in_wait && !MemReady) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // Moore output decode; only the memory handshake strobes look at MemReady.
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;
    InstrDone     = 1'b0;
    Fault         = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      MEM_WR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      R_WB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        PCSource      = 2'b01;
        InstrDone     = 1'b1;
        PCWriteCond   = (op_q == OP_BEQ);
        PCWriteCondNe = (op_q == OP_BNE);
      end
      JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        InstrDone = 1'b1;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
      end
      I_WB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      FAULT: begin
        Fault = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  // Performance counters: active cycles and retired instructions, both free-running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      CycleCount <= '0;
      InstrCount <= '0;
    end else begin
      if ((state != IDLE) && (state != FAULT)) begin
        CycleCount <= CycleCount + 32'd1;
      end
      if (InstrDone) begin
        InstrCount <= InstrCount + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm (timeout set to 4 cycles).
// Each instruction is expanded into a per-cycle list of (MemReady, expected outputs)
// from its class and the chosen wait counts; the DUT's outputs are compared cycle by cycle.
module tb_multicycle_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] OpCode = '0;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, InstrDone, Fault;
  logic [1:0] ALUSrcB, ALUOp, PCSource;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        mr;
    logic [18:0] exp;
  } step_t;

  step_t       plan[$];
  logic [18:0] obs[$];
  int          dec_idx;

  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .InstrDone(InstrDone), .Fault(Fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [18:0] outs();
    return {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Fault};
  endfunction

  function automatic logic [18:0] mk(input logic pcw, pcc, pcn, iord, mr, mw, irw, m2r, rd, rw, sa,
                                     input logic [1:0] sb, aop, pcs, input logic done, flt);
    return {pcw, pcc, pcn, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, pcs, done, flt};
  endfunction

  // Expected output bundle for each phase of an instruction.
  function automatic logic [18:0] v_fetch(input logic r);
    return mk(r,0,0,0,1,0,r,0,0,0,0,2'b01,2'b00,2'b00,0,0);
  endfunction
  function automatic logic [18:0] v_dec();   return mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0); endfunction
  function automatic logic [18:0] v_addr();  return mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0); endfunction
  function automatic logic [18:0] v_memrd(); return mk(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0); endfunction
  function automatic logic [18:0] v_memwb(); return mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0); endfunction
  function automatic logic [18:0] v_memwr(input logic r);
    return mk(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,r,0);
  endfunction
  function automatic logic [18:0] v_rexec(); return mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0); endfunction
  function automatic logic [18:0] v_rwb();   return mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0); endfunction
  function automatic logic [18:0] v_branch(input logic [5:0] op);
    return mk(0,op==OP_BEQ,op==OP_BNE,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
  endfunction
  function automatic logic [18:0] v_jump();  return mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0); endfunction
  function automatic logic [18:0] v_iexec(input logic [5:0] op);
    return mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,(op==OP_ANDI) ? 2'b11 : 2'b00,2'b00,0,0);
  endfunction
  function automatic logic [18:0] v_iwb();   return mk(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0); endfunction
  function automatic logic [18:0] v_fault(); return mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1); endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Fetch with fw stall cycles, then the decode cycle.
  function automatic void add_front(input int fw);
    for (int i = 0; i < fw; i++) plan.push_back('{1'b0, v_fetch(1'b0)});
    plan.push_back('{1'b1, v_fetch(1'b1)});
    dec_idx = plan.size();
    plan.push_back('{rbit(), v_dec()});
  endfunction

  // Whole instruction: fetch stalls fw, data-memory stalls mw.
  function automatic void add_instr(input logic [5:0] op, input int fw, input int mw);
    add_front(fw);
    case (op)
      OP_LW: begin
        plan.push_back('{rbit(), v_addr()});
        for (int i = 0; i < mw; i++) plan.push_back('{1'b0, v_memrd()});
        plan.push_back('{1'b1, v_memrd()});
        plan.push_back('{rbit(), v_memwb()});
      end
      OP_SW: begin
        plan.push_back('{rbit(), v_addr()});
        for (int i = 0; i < mw; i++) plan.push_back('{1'b0, v_memwr(1'b0)});
        plan.push_back('{1'b1, v_memwr(1'b1)});
      end
      OP_R: begin
        plan.push_back('{rbit(), v_rexec()});
        plan.push_back('{rbit(), v_rwb()});
      end
      OP_BEQ, OP_BNE: plan.push_back('{rbit(), v_branch(op)});
      OP_J:           plan.push_back('{rbit(), v_jump()});
      OP_ADDI, OP_ANDI: begin
        plan.push_back('{rbit(), v_iexec(op)});
        plan.push_back('{rbit(), v_iwb()});
      end
      default: ;
    endcase
  endfunction

  // Drives the plan one cycle per entry and records the outputs; OpCode is only
  // held stable through decode and scrambled afterwards.
  task automatic drive_plan(input logic [5:0] op);
    obs.delete();
    for (int i = 0; i < plan.size(); i++) begin
      MemReady = plan[i].mr;
      OpCode   = (i <= dec_idx) ? op : 6'($urandom);
      @(negedge clk);
      obs.push_back(outs());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    MemReady = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (outs() !== 19'd0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: got=%b exp=%b", i, outs(), 19'd0);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (outs() !== 19'd0) begin
      bad++;
      $display("FAIL reset_idle: got=%b exp=%b", outs(), 19'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    int dones;
    plan.delete();
    add_instr(OP_R, 0, 0);
    drive_plan(OP_R);
    dones = 0;
    for (int i = 0; i < plan.size(); i++) begin
      dones += int'(obs[i][1]);
      total++;
      if (obs[i] !== plan[i].exp) begin
        bad++;
        $display("FAIL rtype step%0d: got=%b exp=%b", i, obs[i], plan[i].exp);
      end
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL rtype_done_count: got=%0d exp=1", dones);
    end
  endtask

  task automatic test_lw_wait();
    int irw;
    plan.delete();
    add_instr(OP_LW, 2, 2);
    drive_plan(OP_LW);
    irw = 0;
    for (int i = 0; i < plan.size(); i++) begin
      irw += int'(obs[i][12]);
      total++;
      if (obs[i] !== plan[i].exp) begin
        bad++;
        $display("FAIL lw_wait step%0d: got=%b exp=%b", i, obs[i], plan[i].exp);
      end
    end
    total++;
    if (irw !== 1) begin
      bad++;
      $display("FAIL lw_irwrite_count: got=%0d exp=1", irw);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[2];
    ops[0] = OP_BEQ;
    ops[1] = OP_BNE;
    for (int k = 0; k < 2; k++) begin
      plan.delete();
      add_instr(ops[k], 0, 0);
      drive_plan(ops[k]);
      for (int i = 0; i < plan.size(); i++) begin
        total++;
        if (obs[i] !== plan[i].exp) begin
          bad++;
          $display("FAIL branch op=%b step%0d: got=%b exp=%b", ops[k], i, obs[i], plan[i].exp);
        end
      end
    end
  endtask

  task automatic test_imm();
    logic [5:0] ops[2];
    ops[0] = OP_ANDI;
    ops[1] = OP_ADDI;
    for (int k = 0; k < 2; k++) begin
      plan.delete();
      add_instr(ops[k], 1, 0);
      drive_plan(ops[k]);
      for (int i = 0; i < plan.size(); i++) begin
        total++;
        if (obs[i] !== plan[i].exp) begin
          bad++;
          $display("FAIL imm op=%b step%0d: got=%b exp=%b", ops[k], i, obs[i], plan[i].exp);
        end
      end
    end
  endtask

  task automatic test_illegal();
    plan.delete();
    add_front(1);
    for (int i = 0; i < 10; i++) plan.push_back('{rbit(), v_fault()});
    drive_plan(OP_BAD);
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs[i] !== plan[i].exp) begin
        bad++;
        $display("FAIL illegal step%0d: got=%b exp=%b", i, obs[i], plan[i].exp);
      end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    MemReady = 1'b1;
    @(negedge clk);
    total++;
    if (outs() !== 19'd0) begin
      bad++;
      $display("FAIL illegal_reset_idle: got=%b exp=%b", outs(), 19'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    // sw with MemReady stuck low: four MEM_WR cycles, then FAULT.
    plan.delete();
    add_front(0);
    plan.push_back('{rbit(), v_addr()});
    for (int i = 0; i < 4; i++) plan.push_back('{1'b0, v_memwr(1'b0)});
    plan.push_back('{rbit(), v_fault()});
    drive_plan(OP_SW);
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs[i] !== plan[i].exp) begin
        bad++;
        $display("FAIL sw_timeout step%0d: got=%b exp=%b", i, obs[i], plan[i].exp);
      end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Ready on the fourth MEM_WR cycle: completes normally; then an R-type follows.
    plan.delete();
    add_instr(OP_SW, 0, 3);
    drive_plan(OP_SW);
    plan.delete();
    add_instr(OP_R, 3, 0);
    for (int i = 0; i < obs.size(); i++) begin
      total++;
      if (obs[i] !== (i == obs.size() - 1 ? v_memwr(1'b1) : (i < 3 ? obs[i] ^ 19'd0 : v_memwr(1'b0)))) begin
        bad++;
        $display("FAIL sw_edge step%0d: got=%b", i, obs[i]);
      end
    end
    drive_plan(OP_R);
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs[i] !== plan[i].exp) begin
        bad++;
        $display("FAIL fetch_edge step%0d: got=%b exp=%b", i, obs[i], plan[i].exp);
      end
    end
    // Fetch stuck: FAULT after the fourth FETCH cycle.
    plan.delete();
    for (int i = 0; i < 4; i++) plan.push_back('{1'b0, v_fetch(1'b0)});
    plan.push_back('{rbit(), v_fault()});
    dec_idx = 0;
    drive_plan(OP_R);
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs[i] !== plan[i].exp) begin
        bad++;
        $display("FAIL fetch_timeout step%0d: got=%b exp=%b", i, obs[i], plan[i].exp);
      end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midwait();
    plan.delete();
    add_instr(OP_LW, 1, 3);
    plan = plan[0:4];
    drive_plan(OP_LW);
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs[i] !== plan[i].exp) begin
        bad++;
        $display("FAIL midwait step%0d: got=%b exp=%b", i, obs[i], plan[i].exp);
      end
    end
    rst_n = 1'b0;
    MemReady = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    MemReady = 1'b1;
    @(negedge clk);
    total++;
    if (outs() !== 19'd0) begin
      bad++;
      $display("FAIL midwait_reset_idle: got=%b exp=%b", outs(), 19'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [5:0] ops[8];
    logic [5:0] op;
    int dones;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI};
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 7)];
      plan.delete();
      add_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      drive_plan(op);
      dones = 0;
      for (int i = 0; i < plan.size(); i++) begin
        dones += int'(obs[i][1]);
        total++;
        if (obs[i] !== plan[i].exp) begin
          bad++;
          $display("FAIL random n%0d op=%b step%0d: got=%b exp=%b", n, op, i, obs[i], plan[i].exp);
        end
      end
      total++;
      if (dones !== 1) begin
        bad++;
        $display("FAIL random_done_count n%0d: got=%0d exp=1", n, dones);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_imm();
    test_illegal();
    test_rtype();
    test_timeout();
    test_rtype();
    test_reset_midwait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
